// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that merges write-back requests from several producers
//   (ALU, load unit, ...) onto the single register-file write port, and decodes
//   the winning register id into a registered one-hot wordline with aligned data.
//
// Parameters
//   NUM_REGS  : number of registers (power of two, 2..64)
//   ID_W      : register id width, normally log2(NUM_REGS)
//   DATA_W    : write data width
//   NUM_PORTS : number of requesting producers (1..4)
//   ZERO_REG  : 1 = writes to register 0 are consumed but never drive a wordline
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   wr_valid_i   : per-port write request
//   wr_id_i      : per-port register id, port p at [p*ID_W +: ID_W]
//   wr_data_i    : per-port write data, port p at [p*DATA_W +: DATA_W]
//   wr_ready_o   : per-port grant, combinational, one-hot or zero
//   wordline_o   : registered one-hot register write enable
//   wdata_o      : registered write data, aligned with wordline_o
//   wr_err_o     : registered one-cycle pulse for an out-of-range accepted id
//   stall_cnt_o  : saturating count of cycles where a valid port was not granted
//   stall_clr_i  : synchronous clear of stall_cnt_o
module reg_write_arbiter #(
  parameter int NUM_REGS  = 16,
  parameter int ID_W      = 4,
  parameter int DATA_W    = 16,
  parameter int NUM_PORTS = 2,
  parameter int ZERO_REG  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      wr_valid_i,
  input  logic [NUM_PORTS*ID_W-1:0] wr_id_i,
  input  logic [NUM_PORTS*DATA_W-1:0] wr_data_i,
  output logic [NUM_PORTS-1:0]      wr_ready_o,
  output logic [NUM_REGS-1:0]       wordline_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic                      wr_err_o,
  output logic [7:0]                stall_cnt_o,
  input  logic                      stall_clr_i
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]     rrPtr_q, rrPtr_d;
  logic [NUM_PORTS-1:0] grant;
  logic [PTR_W-1:0]     grantIdx;
  logic                 grantAny;
  logic [PTR_W-1:0]     scanIdx;
  logic [ID_W-1:0]      selId;
  logic [DATA_W-1:0]    selData;
  logic                 inRange;
  logic                 stallEvent;

  logic [NUM_REGS-1:0]  wordline_q, wordline_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 wrErr_q, wrErr_d;
  logic [7:0]           stallCnt_q, stallCnt_d;

  // Round-robin scan: start at rrPtr_q and take the first valid port found,
  // wrapping modulo NUM_PORTS. With a single port this degenerates to
  // ready = valid, so the lone producer is never held off.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    grantAny = 1'b0;
    scanIdx  = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      scanIdx = PTR_W'((int'(rrPtr_q) + off) % NUM_PORTS);
      if (!grantAny && wr_valid_i[scanIdx]) begin
        grantAny        = 1'b1;
        grant[scanIdx]  = 1'b1;
        grantIdx        = scanIdx;
      end
    end
  end

  assign wr_ready_o = grant;

  // AND-OR mux of the winning port's id and data; grant is one-hot or zero,
  // so at most one term contributes.
  always_comb begin
    selId   = '0;
    selData = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        selId   = wr_id_i[p*ID_W +: ID_W];
        selData = wr_data_i[p*DATA_W +: DATA_W];
      end
    end
  end

  // Only reachable when ID_W is wider than log2(NUM_REGS).
  assign inRange = ({1'b0, selId} < (ID_W+1)'(NUM_REGS));

  // A valid port that lost arbitration this cycle counts as a stall.
  assign stallEvent = |(wr_valid_i & ~grant);

  // Next-state for the pointer, the decoded write and the stall counter.
  // The pointer moves just past the winner so every port gets a fair turn;
  // wdata keeps its old value when nothing is transferred.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    wordline_d = '0;
    wdata_d    = wdata_q;
    wrErr_d    = 1'b0;
    stallCnt_d = stallCnt_q;

    if (grantAny) begin
      rrPtr_d = (grantIdx == PTR_W'(NUM_PORTS-1)) ? '0 : grantIdx + PTR_W'(1);
      wdata_d = selData;
      if (!inRange) begin
        wrErr_d = 1'b1;
      end else if (!(ZERO_REG != 0 && selId == '0)) begin
        wordline_d = NUM_REGS'(1) << selId;
      end
    end

    if (stall_clr_i) begin
      stallCnt_d = 8'd0;
    end else if (stallEvent && stallCnt_q != 8'hFF) begin
      stallCnt_d = stallCnt_q + 8'd1;
    end
  end

  // State registers. Reset drops wordline at once so a write in flight when
  // reset hits never reaches the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q    <= '0;
      wordline_q <= '0;
      wdata_q    <= '0;
      wrErr_q    <= 1'b0;
      stallCnt_q <= 8'd0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      wordline_q <= wordline_d;
      wdata_q    <= wdata_d;
      wrErr_q    <= wrErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign wordline_o  = wordline_q;
  assign wdata_o     = wdata_q;
  assign wr_err_o    = wrErr_q;
  assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Scoreboard bench for reg_write_arbiter. Two instances share the same inputs:
//   dutA with ZERO_REG=0 and dutZ with ZERO_REG=1. A reference model computes
//   the expected grant for the current cycle and the expected registered
//   outputs for the next one; a monitor pops and compares them.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_valid;
  logic [7:0]  wr_id;
  logic [31:0] wr_data;
  logic        stall_clr;

  logic [1:0]  readyA, readyZ;
  logic [15:0] wlA, wlZ, wdA, wdZ;
  logic        errA, errZ;
  logic [7:0]  stA, stZ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] wl;
    logic [15:0] wlZ;
    logic [15:0] wd;
    logic        err;
    logic [7:0]  st;
  } outExp_t;

  logic [1:0] readyQ[$];
  outExp_t    outQ[$];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  reg_write_arbiter #(.NUM_REGS(16), .ID_W(4), .DATA_W(16), .NUM_PORTS(2), .ZERO_REG(0)) dutA (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid), .wr_id_i(wr_id), .wr_data_i(wr_data),
    .wr_ready_o(readyA), .wordline_o(wlA), .wdata_o(wdA), .wr_err_o(errA),
    .stall_cnt_o(stA), .stall_clr_i(stall_clr)
  );

  reg_write_arbiter #(.NUM_REGS(16), .ID_W(4), .DATA_W(16), .NUM_PORTS(2), .ZERO_REG(1)) dutZ (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid), .wr_id_i(wr_id), .wr_data_i(wr_data),
    .wr_ready_o(readyZ), .wordline_o(wlZ), .wdata_o(wdZ), .wr_err_o(errZ),
    .stall_cnt_o(stZ), .stall_clr_i(stall_clr)
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's worth of inputs just after the rising edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [3:0] id0, input logic [15:0] d0,
                               input logic [3:0] id1, input logic [15:0] d1, input logic clr);
    @(posedge clk);
    #1;
    wr_valid  = v;
    wr_id     = {id1, id0};
    wr_data   = {d1, d0};
    stall_clr = clr;
  endtask

  // Reference model, evaluated mid-cycle when inputs are stable. It keeps
  // the round-robin pointer as a plain port number and the stall count as an
  // integer; the expectation for the registered outputs is held one cycle
  // before it is handed to the monitor. Reset throws that expectation away.
  int          mdlPtr = 0;
  int          mdlSt = 0;
  logic [15:0] mdlWd = 16'h0;
  int          mg;
  int          mp;
  logic [3:0]  mId;
  outExp_t     pend;
  bit          pendValid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdlPtr    = 0;
        mdlSt     = 0;
        mdlWd     = 16'h0;
        pendValid = 1'b0;
      end else if (pendValid) begin
        outQ.push_back(pend);
      end

      mg = -1;
      for (int k = 0; k < 2; k++) begin
        mp = (mdlPtr + k) % 2;
        if (mg < 0 && wr_valid[mp]) mg = mp;
      end
      readyQ.push_back((mg >= 0) ? 2'(1 << mg) : 2'b00);

      pend.wl  = 16'h0;
      pend.wlZ = 16'h0;
      pend.err = 1'b0;
      if (rst_n) begin
        if (mg >= 0) begin
          mId      = wr_id[mg*4 +: 4];
          pend.wl  = 16'h1 << mId;
          pend.wlZ = (mId == 4'd0) ? 16'h0 : (16'h1 << mId);
          mdlWd    = wr_data[mg*16 +: 16];
          mdlPtr   = (mg + 1) % 2;
        end
        if (stall_clr) mdlSt = 0;
        else if ($countones(wr_valid) > ((mg >= 0) ? 1 : 0) && mdlSt < 255) mdlSt = mdlSt + 1;
      end
      pend.wd   = mdlWd;
      pend.st   = 8'(mdlSt);
      pendValid = 1'b1;
    end
  end

  // Monitor: compares the DUT outputs against whatever the model queued.
  outExp_t    e;
  logic [1:0] r;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (readyQ.size() > 0) begin
        r = readyQ.pop_front();
        checkOutput("wr_ready", 32'(readyA), 32'(r));
        checkOutput("wr_ready_z", 32'(readyZ), 32'(r));
      end
      if (outQ.size() > 0) begin
        e = outQ.pop_front();
        checkOutput("wordline", 32'(wlA), 32'(e.wl));
        checkOutput("wordline_z", 32'(wlZ), 32'(e.wlZ));
        checkOutput("wdata", 32'(wdA), 32'(e.wd));
        checkOutput("wdata_z", 32'(wdZ), 32'(e.wd));
        checkOutput("wr_err", 32'(errA), 32'(e.err));
        checkOutput("wr_err_z", 32'(errZ), 32'(e.err));
        checkOutput("stall_cnt", 32'(stA), 32'(e.st));
        checkOutput("stall_cnt_z", 32'(stZ), 32'(e.st));
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    rst_n     = 1'b0;
    wr_valid  = 2'b00;
    wr_id     = 8'h0;
    wr_data   = 32'h0;
    stall_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_wordline", 32'(wlA), 32'h0);
    checkOutput("rst_wdata", 32'(wdA), 32'h0);
    checkOutput("rst_err", 32'(errA), 32'h0);
    checkOutput("rst_stall", 32'(stA), 32'h0);
    checkOutput("rst_ready_idle", 32'(readyA), 32'h0);
    rst_n = 1'b1;

    // Both ports hammer register 3: grants alternate, four stall cycles.
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 4'd3, 16'h1111, 4'd3, 16'h2222, 1'b0);
    applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    checkOutput("stall_after_4", 32'(stA), 32'd4);
    checkOutput("wl_reg3", 32'(wlA), 32'h0008);

    // Single write of 0xBEEF to register 5 on port 0.
    applyStimulus(2'b01, 4'd5, 16'hBEEF, 4'd0, 16'h0, 1'b0);
    applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    checkOutput("wl_reg5", 32'(wlA), 32'h0020);
    checkOutput("wdata_beef", 32'(wdA), 32'hBEEF);
    applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    checkOutput("wl_reg5_gone", 32'(wlA), 32'h0);

    // Idle sweep over every register id on port 1.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b10, 4'd0, 16'h0, 4'(i), 16'(16'hA500 + i), 1'b0);
      applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
      if (i == 0) begin
        checkOutput("zero_reg_on_wl", 32'(wlZ), 32'h0);
        checkOutput("zero_reg_on_err", 32'(errZ), 32'h0);
        checkOutput("zero_reg_off_wl", 32'(wlA), 32'h0001);
      end
    end

    // Saturate the stall counter, then clear it while still stalling.
    for (int i = 0; i < 300; i++)
      applyStimulus(2'b11, 4'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 1'b0);
    applyStimulus(2'b11, 4'd1, 16'h1, 4'd2, 16'h2, 1'b1);
    checkOutput("stall_sat", 32'(stA), 32'd255);
    applyStimulus(2'b11, 4'd1, 16'h1, 4'd2, 16'h2, 1'b0);
    checkOutput("stall_cleared", 32'(stA), 32'd0);
    applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    checkOutput("stall_resume", 32'(stA), 32'd1);

    // Asynchronous reset while register 10 is being written.
    applyStimulus(2'b01, 4'd10, 16'hCAFE, 4'd0, 16'h0, 1'b0);
    applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    checkOutput("wl_reg10", 32'(wlA), 32'h0400);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("wl_async_rst", 32'(wlA), 32'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    wr_valid = 2'b11;
    wr_id    = {4'd7, 4'd6};
    wr_data  = {16'h7777, 16'h6666};
    @(negedge clk);
    #2;
    checkOutput("rst_grant_port0", 32'(readyA), 32'h1);

    // Randomized traffic with occasional stall clears.
    for (int i = 0; i < 400; i++)
      applyStimulus(2'($urandom), 4'($urandom), 16'($urandom), 4'($urandom), 16'($urandom),
                    ($urandom_range(0, 31) == 0));

    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
